// File: rtl/d_mem_arbiter.sv
// Two-requester data-memory arbiter: zero-latency pass-through when uncontended,
// ownership lock until m_hit_i, round-robin on contention, protocol-error and stall tracking.
module d_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    r0_rden_i,
    input  logic                    r0_wren_i,
    input  logic [ADDR_WIDTH-1:0]   r0_addr_i,
    input  logic [DATA_WIDTH-1:0]   r0_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] r0_wmask_i,
    output logic                    r0_hit_o,
    output logic [DATA_WIDTH-1:0]   r0_rdata_o,
    input  logic                    r1_rden_i,
    input  logic                    r1_wren_i,
    input  logic [ADDR_WIDTH-1:0]   r1_addr_i,
    input  logic [DATA_WIDTH-1:0]   r1_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] r1_wmask_i,
    output logic                    r1_hit_o,
    output logic [DATA_WIDTH-1:0]   r1_rdata_o,
    output logic [ADDR_WIDTH-1:0]   m_addr_o,
    output logic                    m_rden_o,
    output logic                    m_wren_o,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_wmask_o,
    input  logic                    m_hit_i,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i,
    output logic [1:0]              grant_o,
    output logic                    busy_o,
    output logic                    proto_err_o,
    output logic [CNT_WIDTH-1:0]    stall_cnt_o
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} lock_t;

    lock_t                lock_q, lock_d;
    logic                 owner_q, owner_d;
    logic                 prio_q, prio_d;
    logic                 proto_err_q;
    logic [CNT_WIDTH-1:0] stall_q;

    logic req0, req1, granted, sel, sel_rden, sel_wren, illegal, stall;

    assign req0 = r0_rden_i | r0_wren_i;
    assign req1 = r1_rden_i | r1_wren_i;

    // Grant is forced idle while reset is asserted so every output goes quiet immediately.
    always_comb begin
        grant_o = '0;
        if (!rstn_i) begin
            grant_o = '0;
        end else if (lock_q == LOCKED) begin
            grant_o = owner_q ? 2'b10 : 2'b01;
        end else if (req0 && !req1) begin
            grant_o = 2'b01;
        end else if (req1 && !req0) begin
            grant_o = 2'b10;
        end else if (req0 && req1) begin
            grant_o = prio_q ? 2'b10 : 2'b01;
        end
    end

    assign granted  = |grant_o;
    assign sel      = grant_o[1];
    assign sel_rden = sel ? r1_rden_i : r0_rden_i;
    assign sel_wren = sel ? r1_wren_i : r0_wren_i;
    assign illegal  = granted & sel_rden & sel_wren;
    assign stall    = (req0 & ~grant_o[0]) | (req1 & ~grant_o[1]);

    always_comb begin
        m_addr_o  = '0;
        m_rden_o  = 1'b0;
        m_wren_o  = 1'b0;
        m_wdata_o = '0;
        m_wmask_o = '1;
        if (granted) begin
            m_addr_o  = sel ? r1_addr_i  : r0_addr_i;
            m_wdata_o = sel ? r1_wdata_i : r0_wdata_i;
            m_wmask_o = sel ? r1_wmask_i : r0_wmask_i;
            m_wren_o  = sel_wren;
            m_rden_o  = sel_rden & ~sel_wren;
        end
    end

    assign r0_hit_o   = m_hit_i & grant_o[0];
    assign r1_hit_o   = m_hit_i & grant_o[1];
    assign r0_rdata_o = grant_o[0] ? m_rdata_i : '0;
    assign r1_rdata_o = grant_o[1] ? m_rdata_i : '0;

    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        case (lock_q)
            IDLE: begin
                if (granted && !m_hit_i) begin
                    lock_d  = LOCKED;
                    owner_d = sel;
                end
            end
            LOCKED: begin
                if (m_hit_i) lock_d = IDLE;
            end
            default: lock_d = IDLE;
        endcase
        if (granted && m_hit_i) prio_d = ~sel;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lock_q      <= IDLE;
            owner_q     <= 1'b0;
            prio_q      <= 1'b0;
            proto_err_q <= 1'b0;
            stall_q     <= '0;
        end else begin
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            prio_q      <= prio_d;
            proto_err_q <= illegal;
            if (stall && (stall_q != '1))
                stall_q <= stall_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign busy_o      = (lock_q == LOCKED);
    assign proto_err_o = proto_err_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_d_mem_arbiter.sv
// Directed self-checking bench for d_mem_arbiter (inputs driven on negedge, outputs sampled 1ns later).
module tb_d_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = DW/8;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          r0_rden, r0_wren, r1_rden, r1_wren;
    logic [AW-1:0] r0_addr, r1_addr, m_addr;
    logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, m_wdata, m_rdata;
    logic [MW-1:0] r0_wmask, r1_wmask, m_wmask;
    logic          r0_hit, r1_hit, m_rden, m_wren, m_hit, busy, proto_err;
    logic [1:0]    grant;
    logic [CW-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    d_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .r0_rden_i(r0_rden), .r0_wren_i(r0_wren), .r0_addr_i(r0_addr),
        .r0_wdata_i(r0_wdata), .r0_wmask_i(r0_wmask), .r0_hit_o(r0_hit), .r0_rdata_o(r0_rdata),
        .r1_rden_i(r1_rden), .r1_wren_i(r1_wren), .r1_addr_i(r1_addr),
        .r1_wdata_i(r1_wdata), .r1_wmask_i(r1_wmask), .r1_hit_o(r1_hit), .r1_rdata_o(r1_rdata),
        .m_addr_o(m_addr), .m_rden_o(m_rden), .m_wren_o(m_wren), .m_wdata_o(m_wdata),
        .m_wmask_o(m_wmask), .m_hit_i(m_hit), .m_rdata_i(m_rdata),
        .grant_o(grant), .busy_o(busy), .proto_err_o(proto_err), .stall_cnt_o(stall_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_inputs();
        r0_rden = 0; r0_wren = 0; r0_addr = '0; r0_wdata = '0; r0_wmask = '0;
        r1_rden = 0; r1_wren = 0; r1_addr = '0; r1_wdata = '0; r1_wmask = '0;
        m_hit = 0; m_rdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rstn = 0;
        #2 rstn = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rstn = 0;
        #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL rst_grant got=%h exp=%h", grant, 2'b00); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (m_wmask !== 4'hF) begin failures++; $display("FAIL rst_wmask got=%h exp=f", m_wmask); end
        checks++; if (stall_cnt !== 4'h0) begin failures++; $display("FAIL rst_stall got=%h exp=0", stall_cnt); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rst_proto got=%b exp=0", proto_err); end
        #2 rstn = 1;
    endtask

    task automatic test_uncontended();
        do_reset();
        @(negedge clk);
        r0_rden = 1; r0_addr = 32'h100; m_hit = 1; m_rdata = 32'hDEADBEEF;
        #1;
        checks++; if (r0_hit !== 1'b1) begin failures++; $display("FAIL unc_hit got=%b exp=1", r0_hit); end
        checks++; if (r0_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL unc_rdata got=%h exp=deadbeef", r0_rdata); end
        checks++; if (m_addr !== 32'h100 || m_rden !== 1'b1) begin failures++; $display("FAIL unc_fwd got=%h/%b exp=100/1", m_addr, m_rden); end
        checks++; if (r1_rdata !== 32'h0) begin failures++; $display("FAIL unc_r1_rdata got=%h exp=0", r1_rdata); end
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL unc_busy got=%b exp=0", busy); end
        clear_inputs();
    endtask

    task automatic test_contention();
        do_reset();
        @(negedge clk);
        r0_rden = 1; r0_addr = 32'h10; r1_rden = 1; r1_addr = 32'h20;
        #1;
        checks++; if (grant !== 2'b01) begin failures++; $display("FAIL cont_grant0 got=%h exp=01", grant); end
        checks++; if (m_addr !== 32'h10) begin failures++; $display("FAIL cont_addr0 got=%h exp=10", m_addr); end
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b1 || grant !== 2'b01) begin failures++; $display("FAIL cont_lock0 got=%b/%h exp=1/01", busy, grant); end
        checks++; if (stall_cnt !== 4'h1) begin failures++; $display("FAIL cont_stall1 got=%h exp=1", stall_cnt); end
        m_hit = 1; m_rdata = 32'h11;
        #1;
        checks++; if (r0_hit !== 1'b1 || r1_hit !== 1'b0) begin failures++; $display("FAIL cont_hit0 got=%b%b exp=01", r1_hit, r0_hit); end
        @(negedge clk);
        r0_rden = 0; m_hit = 0;
        #1;
        checks++; if (grant !== 2'b10 || m_addr !== 32'h20) begin failures++; $display("FAIL cont_grant1 got=%h/%h exp=10/20", grant, m_addr); end
        checks++; if (stall_cnt !== 4'h2) begin failures++; $display("FAIL cont_stall2 got=%h exp=2", stall_cnt); end
        @(negedge clk);
        m_hit = 1; m_rdata = 32'h22;
        #1;
        checks++; if (r1_hit !== 1'b1 || r1_rdata !== 32'h22) begin failures++; $display("FAIL cont_hit1 got=%b/%h exp=1/22", r1_hit, r1_rdata); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (stall_cnt !== 4'h2 || busy !== 1'b0) begin failures++; $display("FAIL cont_end got=%h/%b exp=2/0", stall_cnt, busy); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        do_reset();
        @(negedge clk);
        r0_rden = 1; r0_addr = 32'hA0; r1_rden = 1; r1_addr = 32'hB0; m_hit = 1;
        for (int i = 0; i < 6; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            checks++; if (grant !== exp_g) begin failures++; $display("FAIL rr_grant%0d got=%h exp=%h", i, grant, exp_g); end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (stall_cnt !== 4'h6) begin failures++; $display("FAIL rr_stall got=%h exp=6", stall_cnt); end
    endtask

    task automatic test_lock_integrity();
        do_reset();
        @(negedge clk);
        r1_wren = 1; r1_addr = 32'h200; r1_wdata = 32'hCAFE0000; r1_wmask = 4'h3;
        #1;
        checks++; if (grant !== 2'b10 || m_wren !== 1'b1 || m_wmask !== 4'h3) begin failures++; $display("FAIL lock_start got=%h/%b/%h exp=10/1/3", grant, m_wren, m_wmask); end
        @(negedge clk);
        r0_rden = 1; r0_addr = 32'h300;
        #1;
        checks++; if (m_addr !== 32'h200 || m_rden !== 1'b0 || grant !== 2'b10) begin failures++; $display("FAIL lock_hold1 got=%h/%b/%h exp=200/0/10", m_addr, m_rden, grant); end
        @(negedge clk);
        #1;
        checks++; if (m_addr !== 32'h200 || m_wdata !== 32'hCAFE0000) begin failures++; $display("FAIL lock_hold2 got=%h/%h exp=200/cafe0000", m_addr, m_wdata); end
        m_hit = 1;
        #1;
        checks++; if (r1_hit !== 1'b1 || r0_hit !== 1'b0) begin failures++; $display("FAIL lock_hit got=%b%b exp=10", r1_hit, r0_hit); end
        @(negedge clk);
        r1_wren = 0; m_hit = 0;
        #1;
        checks++; if (m_addr !== 32'h300 || grant !== 2'b01) begin failures++; $display("FAIL lock_next got=%h/%h exp=300/01", m_addr, grant); end
        clear_inputs();
    endtask

    task automatic test_illegal();
        do_reset();
        @(negedge clk);
        r0_rden = 1; r0_wren = 1; r0_addr = 32'h40; m_hit = 1;
        #1;
        checks++; if (m_rden !== 1'b0 || m_wren !== 1'b1) begin failures++; $display("FAIL ill_fwd got=%b%b exp=01", m_rden, m_wren); end
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL ill_err_early got=%b exp=0", proto_err); end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL ill_err_pulse got=%b exp=1", proto_err); end
        @(negedge clk);
        #1;
        checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL ill_err_clear got=%b exp=0", proto_err); end
    endtask

    task automatic test_saturation();
        do_reset();
        @(negedge clk);
        r0_rden = 1; r0_addr = 32'h50; r1_wren = 1; r1_addr = 32'h60;
        repeat (14) @(negedge clk);
        #1;
        checks++; if (stall_cnt !== 4'hE) begin failures++; $display("FAIL sat_14 got=%h exp=e", stall_cnt); end
        repeat (6) @(negedge clk);
        #1;
        checks++; if (stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_20 got=%h exp=f", stall_cnt); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        @(negedge clk);
        r1_wren = 1; r1_addr = 32'h200; r1_wmask = 4'h3;
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b1 || grant !== 2'b10) begin failures++; $display("FAIL rml_locked got=%b/%h exp=1/10", busy, grant); end
        rstn = 0; r0_rden = 1; r0_addr = 32'h44; m_hit = 1;
        #1;
        checks++; if (busy !== 1'b0 || grant !== 2'b00 || m_wren !== 1'b0 || m_addr !== 32'h0 || m_wmask !== 4'hF || r1_hit !== 1'b0)
            begin failures++; $display("FAIL rml_idle got=busy%b grant%h wren%b addr%h mask%h hit%b exp=busy0 grant0 wren0 addr0 maskf hit0", busy, grant, m_wren, m_addr, m_wmask, r1_hit); end
        @(negedge clk);
        m_hit = 0;
        rstn = 1;
        #1;
        checks++; if (grant !== 2'b01 || m_addr !== 32'h44) begin failures++; $display("FAIL rml_prio got=%h/%h exp=01/44", grant, m_addr); end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_uncontended();
        test_contention();
        test_round_robin();
        test_lock_integrity();
        test_illegal();
        test_saturation();
        test_reset_mid_lock();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
